exec_mem_stage_buf: RTL and testbench
=====================================

Name: exec_mem_stage_buf

Overview:
Parametrised successor to the EX/MEM pipeline register, sitting between the execute stage and the memory stage.
- Captures the ALU result, Rs/Rd operand data, destination register index and memory/writeback control bits.
- Adds valid/ready flow control so the memory stage can stall the pipe, a synchronous flush that injects bubbles, and an optional 2-entry skid buffer so `in_ready` is fully registered.
- Replaces the split negedge-write/posedge-read scheme with a single rising-edge register.

Parameters:
- DATA_W, default 16: width of ALU result and of Rs/Rd data.
- REG_AW, default 3: width of the destination register index.
- SKID_EN, default 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming beats this cycle.
- in_valid  in  1  execute stage presents a beat.
- in_ready  out  1  stage can accept a beat.
- alu_result  in  DATA_W  ALU output.
- rs_data  in  DATA_W  Rs operand.
- rd_data  in  DATA_W  Rd operand (store data).
- rd  in  REG_AW  destination register index.
- mem_read  in  1  load control.
- mem_write  in  1  store control.
- reg_write  in  1  writeback control.
- out_valid  out  1  memory stage beat valid.
- out_ready  in  1  memory stage accepts beat.
- alu_result_mem, rs_data_mem, rd_data_mem  out  DATA_W each  registered payload.
- rd_mem  out  REG_AW  registered destination index.
- mem_read_mem, mem_write_mem, reg_write_mem  out  1 each  registered control, gated by out_valid.

Behaviour:
- Clocking and reset
  - Single clock, rising-edge only.
  - rst is synchronous, active-high, and has priority over everything.
  - On the reset edge: main and skid entries invalid, all payload registers zero, all outputs zero, `in_ready`=0 while rst is high.
  - `in_ready`=1 on the first cycle after rst deasserts.
- Transfers
  - An input transfer occurs when `in_valid` and `in_ready` are both high.
  - An output transfer occurs when `out_valid` and `out_ready` are both high.
- Latency
  - 1 cycle: a beat accepted at edge N is visible on the `*_mem` outputs after edge N (i.e. in cycle N+1).
- Payload hold
  - Payload does not change while `out_valid`=1 and `out_ready`=0.
- Control gating
  - The `*_mem` control outputs equal the stored bits AND `out_valid`, so a bubble never issues a load, store or writeback.
  - Data outputs may hold stale values while invalid.
- SKID_EN=1
  - State is the main entry (drives outputs) plus a skid entry.
  - `in_ready` = NOT skid_valid, taken directly from a flop.
  - Main empty or draining, skid empty: input loads the main entry.
  - Main full and not draining: input loads the skid entry; `in_ready` drops next cycle.
  - When main drains and skid is full: skid moves to main. A simultaneous input is impossible because `in_ready`=0.
  - Throughput is 1 beat/cycle when `out_ready` is held high.
- SKID_EN=0
  - Main entry only; `in_ready` = NOT out_valid OR out_ready (combinational).
  - Skid logic is not generated.
- Flush
  - On a rising edge with flush=1 and rst=0, both entries become invalid and any same-cycle input beat is discarded.
  - Payload data registers are left unchanged; `in_ready`=1 the following cycle.
  - Flush has priority over input and output transfers. An output transfer coincident with flush is still considered consumed by the downstream stage.
- Other rules
  - No width conversion; all fields pass bit-exact.
  - Reset asserted mid-stall drops both entries.
  - `out_valid` is never high while rst is high.

Decomposition:
- Shared package `pipe_pkg`:
  - DATA_W and REG_AW defaults.
  - Packed struct `exmem_payload_t` holding alu_result, rs_data, rd_data, rd, mem_read, mem_write, reg_write, reused by the other stage buffers.
- One sub-module, `pipe_skid_entry`: a valid-plus-payload register with load, clear and reset. It is instantiated once for the main entry and once for the skid entry (skid instance only when SKID_EN=1).
- The top level holds the steering and ready logic.

Test Plan:
1. Reset then stream, SKID_EN=1:
   - Stimulus: assert rst 2 cycles; then apply alu_result=16'h0010, rd=3, reg_write=1, `in_valid`=1, `out_ready`=1.
   - Response: outputs zero during rst; next cycle `out_valid`=1, alu_result_mem=16'h0010, rd_mem=3, reg_write_mem=1.
2. Back-to-back throughput:
   - Stimulus: beats 16'h0001..16'h0008 on consecutive cycles with `out_ready`=1.
   - Response: `in_ready` stays 1; outputs 1..8 appear in order, one per cycle, no gaps.
3. Stall and skid:
   - Stimulus: beat A=16'hAAAA accepted, then `out_ready`=0 while beat B=16'hBBBB is presented.
   - Response: B enters the skid entry; `in_ready`=0 next cycle; A held on the outputs.
   - Stimulus: release `out_ready`.
   - Response: A then B are output, `in_ready` returns to 1, and no beat is lost or duplicated.
4. Flush with both entries full:
   - Stimulus: assert flush for 1 cycle while in_valid=1, presenting C with mem_write=1.
   - Response: `out_valid`=0, mem_write_mem=0 next cycle, C never appears, `in_ready`=1.
5. Control gating:
   - Stimulus: present beat D with mem_read=1 and in_valid=0.
   - Response: mem_read_mem remains 0 and `out_valid`=0.
6. SKID_EN=0 variant:
   - Stimulus: hold `out_ready`=0 with one beat held.
   - Response: `in_ready`=0 in the same cycle; raising `out_ready` makes `in_ready`=1 combinationally, and a new beat is accepted on that same edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: default field widths and
// the EX/MEM payload layout, ordered exactly as the stage buffers pack it.
package pipe_pkg;

  localparam int PIPE_DATA_W = 16;
  localparam int PIPE_REG_AW = 3;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] alu_result;
    logic [PIPE_DATA_W-1:0] rs_data;
    logic [PIPE_DATA_W-1:0] rd_data;
    logic [PIPE_REG_AW-1:0] rd;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
  } exmem_payload_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid-plus-payload holding register. Clear drops only the valid bit;
// load beats drop so that a drain and refill on the same edge keeps the entry full.
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_mem_stage_buf.sv
// EX/MEM stage buffer with valid/ready flow control, flush, and an optional
// skid entry that keeps in_ready off the downstream combinational path.
module exec_mem_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int REG_AW  = PIPE_REG_AW,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [REG_AW-1:0] rd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result_mem,
  output logic [DATA_W-1:0] rs_data_mem,
  output logic [DATA_W-1:0] rd_data_mem,
  output logic [REG_AW-1:0] rd_mem,
  output logic              mem_read_mem,
  output logic              mem_write_mem,
  output logic              reg_write_mem
);

  localparam int PW = 3*DATA_W + REG_AW + 3;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic          main_v;
  logic          main_load;
  logic          in_xfer;
  logic          drain;
  logic [2:0]    ctl_q;

  assign in_pl   = {alu_result, rs_data, rd_data, rd, mem_read, mem_write, reg_write};
  assign in_xfer = in_valid & in_ready;
  assign drain   = main_v & out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic          skid_v;
      logic [PW-1:0] skid_q;
      logic          skid_load;

      // Ready comes straight from the skid flop; the rst term only masks it during reset.
      assign in_ready  = ~skid_v & ~rst;
      assign skid_load = in_xfer & main_v & ~out_ready;
      assign main_load = (drain & skid_v) | (in_xfer & ~(main_v & ~out_ready));
      assign main_d    = skid_v ? skid_q : in_pl;

      pipe_skid_entry #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .load  (skid_load),
        .drop  (drain & skid_v),
        .d     (in_pl),
        .valid (skid_v),
        .q     (skid_q)
      );
    end else begin : g_noskid
      assign in_ready  = (~main_v | out_ready) & ~rst;
      assign main_load = in_xfer;
      assign main_d    = in_pl;
    end
  endgenerate

  pipe_skid_entry #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .load  (main_load),
    .drop  (drain),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  assign {alu_result_mem, rs_data_mem, rd_data_mem, rd_mem, ctl_q} = main_q;

  // Bubbles must never issue a load, store or writeback.
  assign out_valid     = main_v & ~rst;
  assign mem_read_mem  = ctl_q[2] & out_valid;
  assign mem_write_mem = ctl_q[1] & out_valid;
  assign reg_write_mem = ctl_q[0] & out_valid;

endmodule

// File: tb/tb_exec_mem_stage_buf.sv
// Directed bench: skid variant checked through an expected-beat queue and an
// independent output monitor; no-skid variant checked directly.
module tb_exec_mem_stage_buf;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [15:0] alu_result = 0, rs_data = 0, rd_data = 0;
  logic [2:0]  rd = 0;
  logic        mem_read = 0, mem_write = 0, reg_write = 0;
  logic [15:0] alu_result_mem, rs_data_mem, rd_data_mem;
  logic [2:0]  rd_mem;
  logic        mem_read_mem, mem_write_mem, reg_write_mem;

  logic        in_valid0 = 0, out_ready0 = 0;
  logic        in_ready0, out_valid0;
  logic [15:0] alu0 = 0;
  logic [15:0] alu0_mem, rs0_mem, rdd0_mem;
  logic [2:0]  rd0_mem;
  logic        mr0_mem, mw0_mem, rw0_mem;

  exec_mem_stage_buf #(.DATA_W(16), .REG_AW(3), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs_data(rs_data), .rd_data(rd_data), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_mem(alu_result_mem), .rs_data_mem(rs_data_mem), .rd_data_mem(rd_data_mem),
    .rd_mem(rd_mem), .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .reg_write_mem(reg_write_mem)
  );

  exec_mem_stage_buf #(.DATA_W(16), .REG_AW(3), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid0), .in_ready(in_ready0),
    .alu_result(alu0), .rs_data(16'h1234), .rd_data(16'h5678), .rd(3'd5),
    .mem_read(1'b0), .mem_write(1'b1), .reg_write(1'b0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .alu_result_mem(alu0_mem), .rs_data_mem(rs0_mem), .rd_data_mem(rdd0_mem),
    .rd_mem(rd0_mem), .mem_read_mem(mr0_mem), .mem_write_mem(mw0_mem),
    .reg_write_mem(rw0_mem)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int pops = 0;
  exmem_payload_t sb[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exmem_payload_t mk(logic [15:0] a, logic [15:0] s, logic [15:0] d,
                                        logic [2:0] r, logic mr, logic mw, logic rw);
    exmem_payload_t p;
    p.alu_result = a; p.rs_data = s; p.rd_data = d; p.rd = r;
    p.mem_read = mr; p.mem_write = mw; p.reg_write = rw;
    return p;
  endfunction

  task automatic drive(exmem_payload_t p);
    alu_result = p.alu_result; rs_data = p.rs_data; rd_data = p.rd_data; rd = p.rd;
    mem_read = p.mem_read; mem_write = p.mem_write; reg_write = p.reg_write;
  endtask

  // Present a beat, wait (bounded) for acceptance, record it as expected.
  task automatic send(exmem_payload_t p, output int stall);
    int n = 0;
    drive(p);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 for alu %0h", p.alu_result);
    end else begin
      sb.push_back(p);
    end
    stall = n;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exmem_payload_t act;
      act = {alu_result_mem, rs_data_mem, rd_data_mem, rd_mem,
             mem_read_mem, mem_write_mem, reg_write_mem};
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_beat: got alu %0h with nothing expected", act.alu_result);
      end else begin
        chk("out_beat", act, sb.pop_front());
      end
      pops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int p0;
    exmem_payload_t pa;

    // 1: reset, then a single streamed beat
    in_valid = 1'b1;
    drive(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7, 1, 1, 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu", alu_result_mem, 0);
    chk("rst_reg_write", reg_write_mem, 0);
    chk("rst_in_ready_noskid", in_ready0, 0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    send(mk(16'h0010, 16'h0, 16'h0, 3'd3, 0, 0, 1), st);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_reg_write_mem", reg_write_mem, 1);
    cycles(1);

    // 2: back-to-back throughput
    p0 = pops;
    for (int i = 1; i <= 8; i++) begin
      send(mk(16'(i), 16'(i*3), 16'(i*5), 3'(i), i[0], i[1], i[2]), st);
      chk("t2_no_stall", st, 0);
    end
    @(negedge clk); #1;
    chk("t2_pop_count", pops - p0, 8);
    cycles(2);

    // 3: stall fills the skid entry, then release
    out_ready = 1'b0;
    send(mk(16'hAAAA, 16'h1111, 16'h2222, 3'd1, 1, 0, 1), st);
    send(mk(16'hBBBB, 16'h3333, 16'h4444, 3'd2, 0, 1, 0), st);
    @(negedge clk);
    chk("t3_in_ready_low", in_ready, 0);
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_hold_a", alu_result_mem, 16'hAAAA);
    cycles(1);
    @(negedge clk);
    chk("t3_still_a", alu_result_mem, 16'hAAAA);
    chk("t3_still_mem_read", mem_read_mem, 1);
    cycles(1);
    out_ready = 1'b1;
    cycles(3);
    chk("t3_in_ready_back", in_ready, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: flush with both entries full and a beat arriving
    out_ready = 1'b0;
    send(mk(16'hE001, 0, 0, 3'd4, 0, 1, 0), st);
    send(mk(16'hE002, 0, 0, 3'd4, 0, 1, 0), st);
    drive(mk(16'hCCCC, 16'h0, 16'hC0DE, 3'd6, 0, 1, 0));
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_mem_write_mem", mem_write_mem, 0);
    chk("t4_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycles(3);
    chk("t4_still_empty", out_valid, 0);

    // 5: stored control bits with no valid beat stay gated off
    drive(mk(16'hDDDD, 0, 0, 3'd7, 1, 0, 0));
    in_valid = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_mem_read_mem", mem_read_mem, 0);

    // reset in the middle of a stall drops both entries
    cycles(1);
    out_ready = 1'b0;
    send(mk(16'h5151, 0, 0, 3'd1, 0, 0, 1), st);
    send(mk(16'h5252, 0, 0, 3'd2, 0, 0, 1), st);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_after_valid", out_valid, 0);
    chk("mid_rst_after_ready", in_ready, 1);
    out_ready = 1'b1;
    cycles(2);

    // 6: no-skid variant, combinational ready
    out_ready0 = 1'b0;
    alu0 = 16'h0A0A; in_valid0 = 1'b1;
    @(negedge clk);
    chk("t6_ready_empty", in_ready0, 1);
    @(posedge clk);
    #1 alu0 = 16'h0B0B;
    @(negedge clk);
    chk("t6_held_valid", out_valid0, 1);
    chk("t6_held_alu", alu0_mem, 16'h0A0A);
    chk("t6_ready_stalled", in_ready0, 0);
    chk("t6_mem_write_mem", mw0_mem, 1);
    out_ready0 = 1'b1;
    #1;
    chk("t6_ready_comb", in_ready0, 1);
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    @(negedge clk);
    chk("t6_new_valid", out_valid0, 1);
    chk("t6_new_alu", alu0_mem, 16'h0B0B);
    chk("t6_new_rd", rd0_mem, 3'd5);
    cycles(2);
    chk("t6_drained", out_valid0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
